// File: rtl/e203_reset_seq.sv
`default_nettype none
// ============================================================================
//  Module      : e203_reset_seq
//  Description : Staged reset sequencer for the e203 core domains. It
//                synchronises the pin reset and releases the always-on, TCM
//                and core domains in order with programmable gaps. It also
//                handles warm resets from the watchdog, software and debug,
//                and records the cause of the last warm reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module e203_reset_seq #(
    parameter int SYNC_LEVELS = 2,
    parameter int AON_DLY     = 4,
    parameter int TCM_DLY     = 4,
    parameter int CORE_DLY    = 8,
    parameter int HOLD_CYC    = 16,
    parameter int CNT_W       = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       test_mode,
    input  logic       wdg_rst_req,
    input  logic       sw_rst_req,
    input  logic       dbg_ndmreset,
    output logic       rst_aon,
    output logic       rst_itcm,
    output logic       rst_dtcm,
    output logic       rst_core,
    output logic [1:0] rst_cause,
    output logic       seq_busy
);

    // The RESET-state exit edge acts as the final synchroniser level, so the
    // explicit chain holds one flop fewer than SYNC_LEVELS. The FSM therefore
    // leaves RESET on the SYNC_LEVELS-th edge after rst_n rises.
    localparam int SYNC_W = SYNC_LEVELS - 1;

    localparam logic [CNT_W-1:0] c_cnt_zero  = '0;
    localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_aon_load  = CNT_W'(AON_DLY - 1);
    localparam logic [CNT_W-1:0] c_tcm_load  = CNT_W'(TCM_DLY - 1);
    localparam logic [CNT_W-1:0] c_core_load = CNT_W'(CORE_DLY - 1);
    localparam logic [CNT_W-1:0] c_hold_load = CNT_W'(HOLD_CYC - 1);
    localparam logic [SYNC_W-1:0] c_sync_in  = SYNC_W'(1);

    localparam logic [1:0] c_cause_por = 2'd0;
    localparam logic [1:0] c_cause_wdg = 2'd1;
    localparam logic [1:0] c_cause_sw  = 2'd2;
    localparam logic [1:0] c_cause_dbg = 2'd3;

    typedef enum logic [2:0] {
        S_RESET     = 3'd0,
        S_WAIT_AON  = 3'd1,
        S_WAIT_TCM  = 3'd2,
        S_WAIT_CORE = 3'd3,
        S_RUN       = 3'd4,
        S_HOLD      = 3'd5
    } state_t;

    logic [SYNC_W-1:0] r_sync;
    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [CNT_W-1:0]  w_cnt_dec;
    logic [1:0]        r_cause;
    logic [1:0]        w_cause_nxt;
    logic              r_busy;
    logic              r_aon;
    logic              r_tcm;
    logic              r_core;
    logic              w_sync_rel;
    logic              w_any_req;
    logic              w_level_req;
    logic              w_cnt_done;
    logic              w_aon_nxt;
    logic              w_tcm_nxt;
    logic              w_core_nxt;

    assign w_sync_rel  = r_sync[SYNC_W-1];
    assign w_any_req   = wdg_rst_req | sw_rst_req | dbg_ndmreset;
    assign w_level_req = wdg_rst_req | dbg_ndmreset;
    assign w_cnt_done  = (r_cnt == c_cnt_zero);
    assign w_cnt_dec   = w_cnt_done ? c_cnt_zero : (r_cnt - c_cnt_one);

    // Pin-reset synchroniser: shifts 1s in once rst_n is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= (r_sync << 1) | c_sync_in;
        end
    end

    // Next-state, delay counter and cause selection for the release sequencer.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = w_cnt_dec;
        w_cause_nxt = r_cause;
        case (r_state)
            S_RESET: begin
                w_cnt_nxt = c_cnt_zero;
                if (w_sync_rel) begin
                    w_state_nxt = S_WAIT_AON;
                    w_cnt_nxt   = c_aon_load;
                end
            end
            S_WAIT_AON: begin
                if (w_cnt_done) begin
                    w_state_nxt = S_WAIT_TCM;
                    w_cnt_nxt   = c_tcm_load;
                end
            end
            S_WAIT_TCM: begin
                if (w_cnt_done) begin
                    w_state_nxt = S_WAIT_CORE;
                    w_cnt_nxt   = c_core_load;
                end
            end
            S_WAIT_CORE: begin
                if (w_cnt_done) begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = c_cnt_zero;
                end
            end
            S_RUN: begin
                w_cnt_nxt = c_cnt_zero;
                if (w_any_req) begin
                    w_state_nxt = S_HOLD;
                    w_cnt_nxt   = c_hold_load;
                    // Watchdog outranks debug, debug outranks software.
                    if (wdg_rst_req) begin
                        w_cause_nxt = c_cause_wdg;
                    end else if (dbg_ndmreset) begin
                        w_cause_nxt = c_cause_dbg;
                    end else begin
                        w_cause_nxt = c_cause_sw;
                    end
                end
            end
            S_HOLD: begin
                // Counter saturates at zero while a level request keeps us here.
                if (w_cnt_done && !w_level_req) begin
                    w_state_nxt = S_WAIT_TCM;
                    w_cnt_nxt   = c_tcm_load;
                end
            end
            default: begin
                w_state_nxt = S_RESET;
                w_cnt_nxt   = c_cnt_zero;
                w_cause_nxt = c_cause_por;
            end
        endcase
    end

    // Domain release levels derived from the state being entered.
    always_comb begin
        w_aon_nxt  = (w_state_nxt != S_RESET) && (w_state_nxt != S_WAIT_AON);
        w_tcm_nxt  = (w_state_nxt == S_WAIT_CORE) || (w_state_nxt == S_RUN);
        w_core_nxt = (w_state_nxt == S_RUN);
    end

    // Sequencer state register with the busy flag registered alongside.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_RESET;
            r_cnt   <= c_cnt_zero;
            r_cause <= c_cause_por;
            r_busy  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_cause <= w_cause_nxt;
            r_busy  <= (w_state_nxt != S_RUN);
        end
    end

    // Dedicated reset-output flops: asynchronous assert, synchronous release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_aon  <= 1'b0;
            r_tcm  <= 1'b0;
            r_core <= 1'b0;
        end else begin
            r_aon  <= w_aon_nxt;
            r_tcm  <= w_tcm_nxt;
            r_core <= w_core_nxt;
        end
    end

    // Scan mode hands every domain reset straight to the pin.
    assign rst_aon   = test_mode ? rst_n : r_aon;
    assign rst_itcm  = test_mode ? rst_n : r_tcm;
    assign rst_dtcm  = test_mode ? rst_n : r_tcm;
    assign rst_core  = test_mode ? rst_n : r_core;
    assign rst_cause = r_cause;
    assign seq_busy  = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_e203_reset_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_e203_reset_seq
//  Description : Directed self-checking bench for e203_reset_seq with an
//                event-time reference model compared every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_e203_reset_seq;

    localparam int SYNC = 2;
    localparam int AON  = 4;
    localparam int TCM  = 4;
    localparam int CORE = 8;
    localparam int HOLD = 16;
    localparam int INF  = 32'h3fff_ffff;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       test_mode = 1'b0;
    logic       wdg = 1'b0;
    logic       sw = 1'b0;
    logic       dbg = 1'b0;
    logic       rst_aon;
    logic       rst_itcm;
    logic       rst_dtcm;
    logic       rst_core;
    logic [1:0] rst_cause;
    logic       seq_busy;

    int vec_cnt = 0;
    int err_cnt = 0;

    e203_reset_seq #(
        .SYNC_LEVELS (SYNC),
        .AON_DLY     (AON),
        .TCM_DLY     (TCM),
        .CORE_DLY    (CORE),
        .HOLD_CYC    (HOLD),
        .CNT_W       (5)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .test_mode    (test_mode),
        .wdg_rst_req  (wdg),
        .sw_rst_req   (sw),
        .dbg_ndmreset (dbg),
        .rst_aon      (rst_aon),
        .rst_itcm     (rst_itcm),
        .rst_dtcm     (rst_dtcm),
        .rst_core     (rst_core),
        .rst_cause    (rst_cause),
        .seq_busy     (seq_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: release times are edge numbers derived from the rules.
    int n_edge    = 0;
    bit in_reset  = 1'b1;
    bit holding   = 1'b0;
    int hold_start = 0;
    int aon_rel   = INF;
    int tcm_rel   = INF;
    int core_rel  = INF;
    int m_cause   = 0;

    always @(posedge clk) begin
        logic e_aon, e_tcm, e_core, e_busy;
        logic [1:0] e_cause;
        n_edge++;
        if (!rst_n) begin
            in_reset = 1'b1;
            holding  = 1'b0;
            aon_rel  = INF;
            tcm_rel  = INF;
            core_rel = INF;
            m_cause  = 0;
        end else if (in_reset) begin
            in_reset = 1'b0;
            aon_rel  = (n_edge - 1) + SYNC + AON;
            tcm_rel  = aon_rel + TCM;
            core_rel = tcm_rel + CORE;
        end else if (holding) begin
            if (n_edge >= hold_start + HOLD && !wdg && !dbg) begin
                holding  = 1'b0;
                tcm_rel  = n_edge + TCM;
                core_rel = tcm_rel + CORE;
            end
        end else if (n_edge > core_rel && (wdg || sw || dbg)) begin
            holding    = 1'b1;
            hold_start = n_edge;
            tcm_rel    = INF;
            core_rel   = INF;
            m_cause    = wdg ? 1 : (dbg ? 3 : 2);
        end
        #1;
        e_aon   = test_mode ? rst_n : (n_edge >= aon_rel);
        e_tcm   = test_mode ? rst_n : (n_edge >= tcm_rel);
        e_core  = test_mode ? rst_n : (n_edge >= core_rel);
        e_busy  = !(n_edge >= core_rel);
        e_cause = 2'(m_cause);
        chk("cycle_model",
            {1'b0, rst_aon, rst_itcm, rst_dtcm, rst_core, rst_cause, seq_busy},
            {1'b0, e_aon, e_tcm, e_tcm, e_core, e_cause, e_busy});
    end

    // Return just after the given absolute edge has been processed.
    task automatic at_edge(input int e);
        while (n_edge < e) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic outs(input string name, input logic [3:0] exp);
        chk(name, {4'b0, rst_aon, rst_itcm, rst_dtcm, rst_core}, {4'b0, exp});
    endtask

    initial begin
        int r, t, t2, t3, t4, r2, r3;

        // Reset state while the pin is held low.
        repeat (3) @(negedge clk);
        #1;
        outs("reset_outputs", 4'b0000);
        chk("reset_cause", {6'b0, rst_cause}, 8'd0);
        chk("reset_busy", {7'b0, seq_busy}, 8'd1);

        // Power-on release timing with default delays.
        @(negedge clk);
        rst_n = 1'b1;
        r = n_edge;
        at_edge(r + 5);  outs("por_e5", 4'b0000);
        at_edge(r + 6);  outs("por_aon_e6", 4'b1000);
        at_edge(r + 9);  outs("por_e9", 4'b1000);
        at_edge(r + 10); outs("por_tcm_e10", 4'b1110);
        at_edge(r + 17); outs("por_e17", 4'b1110);
        chk("por_busy_e17", {7'b0, seq_busy}, 8'd1);
        at_edge(r + 18); outs("por_core_e18", 4'b1111);
        chk("por_busy_e18", {7'b0, seq_busy}, 8'd0);
        chk("por_cause", {6'b0, rst_cause}, 8'd0);

        // Single-cycle software request.
        t = r + 25;
        at_edge(t - 1); @(negedge clk); sw = 1'b1;
        at_edge(t);
        outs("sw_enter", 4'b1000);
        chk("sw_cause", {6'b0, rst_cause}, 8'd2);
        @(negedge clk); sw = 1'b0;
        at_edge(t + 19); outs("sw_t19", 4'b1000);
        at_edge(t + 20); outs("sw_tcm_t20", 4'b1110);
        at_edge(t + 27); outs("sw_t27", 4'b1110);
        at_edge(t + 28); outs("sw_core_t28", 4'b1111);

        // Debug level held for 40 cycles stretches the hold.
        t2 = t + 40;
        at_edge(t2 - 1); @(negedge clk); dbg = 1'b1;
        at_edge(t2);
        outs("dbg_enter", 4'b1000);
        chk("dbg_cause", {6'b0, rst_cause}, 8'd3);
        at_edge(t2 + 39);
        outs("dbg_hold_t39", 4'b1000);
        @(negedge clk); dbg = 1'b0;
        at_edge(t2 + 43); outs("dbg_t43", 4'b1000);
        at_edge(t2 + 44); outs("dbg_tcm_t44", 4'b1110);
        at_edge(t2 + 51); outs("dbg_t51", 4'b1110);
        at_edge(t2 + 52); outs("dbg_core_t52", 4'b1111);

        // Simultaneous requests, then a software pulse during WAIT_CORE.
        t3 = t2 + 60;
        at_edge(t3 - 1); @(negedge clk);
        wdg = 1'b1; sw = 1'b1; dbg = 1'b1;
        at_edge(t3);
        chk("simul_cause", {6'b0, rst_cause}, 8'd1);
        @(negedge clk);
        wdg = 1'b0; sw = 1'b0; dbg = 1'b0;
        at_edge(t3 + 23); @(negedge clk); sw = 1'b1;
        at_edge(t3 + 24); @(negedge clk); sw = 1'b0;
        at_edge(t3 + 25);
        chk("simul_ignored_cause", {6'b0, rst_cause}, 8'd1);
        outs("simul_wait_core", 4'b1110);
        at_edge(t3 + 28); outs("simul_core_t28", 4'b1111);

        // Watchdog reset interrupted by the pin during WAIT_TCM.
        t4 = t3 + 40;
        at_edge(t4 - 1); @(negedge clk); wdg = 1'b1;
        at_edge(t4); @(negedge clk); wdg = 1'b0;
        at_edge(t4 + 18); @(negedge clk);
        rst_n = 1'b0;
        #1;
        outs("pin_async_outs", 4'b0000);
        chk("pin_async_cause", {6'b0, rst_cause}, 8'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        r2 = n_edge;
        at_edge(r2 + 5);  outs("rep_e5", 4'b0000);
        at_edge(r2 + 6);  outs("rep_aon_e6", 4'b1000);
        at_edge(r2 + 10); outs("rep_tcm_e10", 4'b1110);
        at_edge(r2 + 18); outs("rep_core_e18", 4'b1111);

        // Scan mode: outputs follow the pin, warm requests do not touch them.
        at_edge(r2 + 25); @(negedge clk);
        test_mode = 1'b1;
        #1; outs("scan_hi", 4'b1111);
        @(negedge clk); rst_n = 1'b0;
        #1; outs("scan_lo", 4'b0000);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1; outs("scan_rise", 4'b1111);
        r3 = n_edge;
        at_edge(r3 + 20); @(negedge clk); wdg = 1'b1;
        @(negedge clk); wdg = 1'b0;
        #1;
        outs("scan_wdg", 4'b1111);
        chk("scan_cause", {6'b0, rst_cause}, 8'd1);
        chk("scan_busy", {7'b0, seq_busy}, 8'd1);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1; outs("scan_lo2", 4'b0000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        test_mode = 1'b0;
        repeat (5) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
`default_nettype wire
